// File: rtl/dmem_responder.sv
// Variable-latency data-memory target for the core's load/store port.
// Holds 2^DEPTH_LOG2 words, supports word and byte accesses, and flags out-of-range or misaligned addresses.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: the requester holds req (and its fields) until ready; the request is taken
  // only in IDLE, ready is a single-cycle strobe, and rdata/err stay put until the next response.

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_we;
  logic        r_byte_en;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [WORDS];

  logic                  w_idle;
  logic                  w_we;
  logic                  w_byte_en;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_fault;
  logic                  w_commit;
  logic [31:0]           w_word;
  logic [7:0]            w_lane_byte;

  // With zero wait states the access completes straight from IDLE, so use the live inputs there.
  assign w_idle    = (r_state == S_IDLE);
  assign w_we      = w_idle ? we      : r_we;
  assign w_byte_en = w_idle ? byte_en : r_byte_en;
  assign w_addr    = w_idle ? addr    : r_addr;
  assign w_wdata   = w_idle ? wdata   : r_wdata;

  assign w_idx       = w_addr[DEPTH_LOG2+1:2];
  assign w_lane      = w_addr[1:0];
  assign w_fault     = (|w_addr[31:DEPTH_LOG2+2]) || (!w_byte_en && (w_lane != 2'd0));
  assign w_word      = r_mem[w_idx];
  assign w_lane_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_commit    = (w_next == S_RESP) && !reset;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = CNT_LOAD;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_byte_en <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      rdata     <= 32'd0;
      err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_idle && req) begin
        r_we      <= we;
        r_byte_en <= byte_en;
        r_addr    <= addr;
        r_wdata   <= wdata;
      end
      if (w_commit) begin
        err <= w_fault;
        if (w_fault || w_we) begin
          rdata <= 32'd0;
        end else if (w_byte_en) begin
          rdata <= {24'd0, w_lane_byte};
        end else begin
          rdata <= w_word;
        end
      end
    end
  end

  // Memory is deliberately not reset; a store aborted by reset never reaches this edge.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_fault) begin
      if (w_byte_en) begin
        r_mem[w_idx][{w_lane, 3'b000} +: 8] <= w_wdata[7:0];
      end else begin
        r_mem[w_idx] <= w_wdata;
      end
    end
  end

  assign ready     = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 3 wait states) checked against a byte-addressed memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:0]  be;
  logic [2:0]  ready;
  logic [2:0]  err;
  logic [2:0]  busy;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [1:0]  dbg   [3];

  int n_cmp  = 0;
  int n_fail = 0;
  int wc [3] = '{2, 0, 3};
  logic [7:0] mb [3][256];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .byte_en(be[0]),
    .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]),
    .err(err[0]), .busy(busy[0]), .dbg_state(dbg[0]));

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .byte_en(be[1]),
    .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]),
    .err(err[1]), .busy(busy[1]), .dbg_state(dbg[1]));

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .byte_en(be[2]),
    .addr(addr[2]), .wdata(wdata[2]), .ready(ready[2]), .rdata(rdata[2]),
    .err(err[2]), .busy(busy[2]), .dbg_state(dbg[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: 256-byte little-endian memory; anything at or above byte 256 or an unaligned word faults.
  function automatic void model(input int d, input logic w, input logic b, input logic [31:0] a,
                                input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int base;
    base = int'(a & 32'hFF);
    e  = (a >= 32'd256) || (!b && (a % 4 != 0));
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        if (b) mb[d][base] = wd[7:0];
        else for (int i = 0; i < 4; i++) mb[d][base + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end else if (b) begin
        rd = {24'd0, mb[d][base]};
      end else begin
        rd = {mb[d][base + 3], mb[d][base + 2], mb[d][base + 1], mb[d][base]};
      end
    end
  endfunction

  task automatic access(input int d, input logic w, input logic b, input logic [31:0] a, input logic [31:0] wd);
    logic        e;
    logic [31:0] rd;
    model(d, w, b, a, wd, e, rd);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    for (int k = 1; k <= wc[d] + 1; k++) begin
      @(negedge clk);
      chk($sformatf("u%0d busy c%0d a=%h", d, k, a), busy[d], 32'd1);
      chk($sformatf("u%0d ready c%0d a=%h", d, k, a), ready[d], (k == wc[d] + 1) ? 32'd1 : 32'd0);
      if (k == wc[d] + 1) begin
        chk($sformatf("u%0d rdata a=%h we=%0d be=%0d", d, a, w, b), rdata[d], rd);
        chk($sformatf("u%0d err a=%h we=%0d be=%0d", d, a, w, b), err[d], {31'd0, e});
        req[d] = 1'b0;
      end
      if (k == 1) begin
        addr[d] = $urandom; wdata[d] = $urandom; we[d] = ~w; be[d] = ~b;
      end
    end
    @(negedge clk);
    chk($sformatf("u%0d ready low after a=%h", d, a), ready[d], 32'd0);
    chk($sformatf("u%0d busy low after a=%h", d, a), busy[d], 32'd0);
    chk($sformatf("u%0d rdata hold a=%h", d, a), rdata[d], rd);
    chk($sformatf("u%0d err hold a=%h", d, a), err[d], {31'd0, e});
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    logic        e_dummy;
    logic [31:0] rd_dummy;
    req = '0; we = '0; be = '0;
    for (int d = 0; d < 3; d++) begin addr[d] = 32'd0; wdata[d] = 32'd0; end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("u%0d reset ready", d), ready[d], 32'd0);
      chk($sformatf("u%0d reset busy", d), busy[d], 32'd0);
      chk($sformatf("u%0d reset rdata", d), rdata[d], 32'd0);
      chk($sformatf("u%0d reset err", d), err[d], 32'd0);
    end
    reset = 1'b0;

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 64; i++) access(d, 1'b1, 1'b0, 32'(i * 4), $urandom);

    // Word and byte store/load on the 2-wait instance.
    access(0, 1'b1, 1'b0, 32'h8, 32'h12345678);
    access(0, 1'b0, 1'b0, 32'h8, 32'h0);
    access(0, 1'b1, 1'b1, 32'h9, 32'h000000AB);
    access(0, 1'b0, 1'b0, 32'h8, 32'h0);
    access(0, 1'b0, 1'b1, 32'h9, 32'h0);
    access(0, 1'b0, 1'b1, 32'hB, 32'h0);

    // Faults.
    access(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    access(0, 1'b0, 1'b0, 32'h6, 32'h0);
    access(0, 1'b0, 1'b0, 32'h0, 32'h0);
    access(0, 1'b0, 1'b0, 32'h4, 32'h0);

    // Reset during BUSY: store is dropped, no ready appears.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 1'b0; addr[0] = 32'h10; wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort busy before reset", busy[0], 32'd1);
    reset = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("abort ready", ready[0], 32'd0);
    chk("abort busy", busy[0], 32'd0);
    chk("abort rdata", rdata[0], 32'd0);
    chk("abort err", err[0], 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort no ready c%0d", k), ready[0], 32'd0);
    end
    access(0, 1'b0, 1'b0, 32'h10, 32'h0);

    // Zero-wait back-to-back stores with req held high.
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    model(1, 1'b1, 1'b0, 32'h0, w0, e_dummy, rd_dummy);
    model(1, 1'b1, 1'b0, 32'h4, w1, e_dummy, rd_dummy);
    model(1, 1'b1, 1'b0, 32'h8, w2, e_dummy, rd_dummy);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 1'b0; addr[1] = 32'h0; wdata[1] = w0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b ready c%0d", k), ready[1], (k % 2 == 1 && k <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("b2b busy c%0d", k), busy[1], (k % 2 == 1 && k <= 5) ? 32'd1 : 32'd0);
      if (k == 1) begin addr[1] = 32'h4; wdata[1] = w1; end
      if (k == 3) begin addr[1] = 32'h8; wdata[1] = w2; end
      if (k == 5) req[1] = 1'b0;
    end
    access(1, 1'b0, 1'b0, 32'h0, 32'h0);
    access(1, 1'b0, 1'b0, 32'h4, 32'h0);
    access(1, 1'b0, 1'b0, 32'h8, 32'h0);

    // Held request on the 3-wait instance; addr/wdata change mid-BUSY must not affect the first store.
    w0 = $urandom; w1 = $urandom;
    model(2, 1'b1, 1'b0, 32'h20, w0, e_dummy, rd_dummy);
    model(2, 1'b1, 1'b0, 32'h24, w1, e_dummy, rd_dummy);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 1'b0; addr[2] = 32'h20; wdata[2] = w0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("held ready c%0d", k), ready[2], (k == 4 || k == 9) ? 32'd1 : 32'd0);
      if (k == 2) begin addr[2] = 32'h24; wdata[2] = w1; end
      if (k == 9) req[2] = 1'b0;
    end
    access(2, 1'b0, 1'b0, 32'h20, 32'h0);
    access(2, 1'b0, 1'b0, 32'h24, 32'h0);

    // Random mix across all instances, occasionally out of range or misaligned.
    for (int n = 0; n < 60; n++) begin
      int          d;
      logic        w;
      logic        b;
      logic [31:0] a;
      d = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 255));
      access(d, w, b, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
